// File: rtl/reg_f_io.sv
// rtl/reg_f_io.sv - register file with memory-mapped bidirectional I/O ports
module reg_f_io #(
    parameter int WIDTH  = 8,
    parameter int SIZE   = 8,
    parameter int NPORTS = 2,
    localparam int AW    = $clog2(SIZE + 2*NPORTS)
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [WIDTH-1:0]         IN,
    input  logic                     EN,
    input  logic [AW-1:0]            SEL,
    input  logic [AW-1:0]            SEL_B,
    output logic [WIDTH-1:0]         OUT,
    output logic [WIDTH-1:0]         OUT_B,
    inout  wire  [NPORTS*WIDTH-1:0]  PORT,
    output logic [NPORTS-1:0]        CHG
);

    logic [WIDTH-1:0] gpr     [SIZE];
    logic [WIDTH-1:0] lat     [NPORTS];
    logic [WIDTH-1:0] dir     [NPORTS];
    logic [WIDTH-1:0] s1      [NPORTS];
    logic [WIDTH-1:0] s2      [NPORTS];
    logic [WIDTH-1:0] s3      [NPORTS];
    logic [WIDTH-1:0] dir_nx  [NPORTS];
    logic [WIDTH-1:0] data_rd [NPORTS];
    logic [NPORTS-1:0] we_data;
    logic [NPORTS-1:0] we_dir;
    logic [NPORTS-1:0] chg_set;

    // Change detection masks with the direction as it will be after this edge.
    always_comb begin
        for (int k = 0; k < NPORTS; k++) begin
            we_data[k] = EN && (SEL == AW'(SIZE + 2*k));
            we_dir[k]  = EN && (SEL == AW'(SIZE + 2*k + 1));
            dir_nx[k]  = we_dir[k] ? IN : dir[k];
            chg_set[k] = |((s2[k] ^ s3[k]) & ~dir_nx[k]);
            data_rd[k] = (lat[k] & dir[k]) | (s2[k] & ~dir[k]);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < SIZE; i++) begin
                gpr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                if (EN && (SEL == AW'(i))) begin
                    gpr[i] <= IN;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < NPORTS; k++) begin
                lat[k] <= '0;
                dir[k] <= '0;
                s1[k]  <= '0;
                s2[k]  <= '0;
                s3[k]  <= '0;
                CHG[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NPORTS; k++) begin
                if (we_data[k]) begin
                    lat[k] <= IN;
                end
                dir[k] <= dir_nx[k];
                s1[k]  <= PORT[k*WIDTH +: WIDTH];
                s2[k]  <= s1[k];
                s3[k]  <= s2[k];
                // A fresh change outranks the clear from a DATA write on the same edge.
                CHG[k] <= chg_set[k] | (CHG[k] & ~we_data[k]);
            end
        end
    end

    always_comb begin
        OUT   = '0;
        OUT_B = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (SEL == AW'(i)) begin
                OUT = gpr[i];
            end
            if (SEL_B == AW'(i)) begin
                OUT_B = gpr[i];
            end
        end
        for (int k = 0; k < NPORTS; k++) begin
            if (SEL == AW'(SIZE + 2*k)) begin
                OUT = data_rd[k];
            end
            if (SEL == AW'(SIZE + 2*k + 1)) begin
                OUT = dir[k];
            end
            if (SEL_B == AW'(SIZE + 2*k)) begin
                OUT_B = data_rd[k];
            end
            if (SEL_B == AW'(SIZE + 2*k + 1)) begin
                OUT_B = dir[k];
            end
        end
    end

    for (genvar k = 0; k < NPORTS; k++) begin : g_port
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            assign PORT[k*WIDTH + b] = dir[k][b] ? lat[k][b] : 1'bz;
        end
    end

endmodule
